symbol_frame_sequencer: RTL
===========================

Name: symbol_frame_sequencer

Overview:
- Sequences the hard-decision slicer stage of the OPBOMP receive path.
- Accepts a stream of signed DATA_WIDTH symbols over a valid/ready handshake and slices each to one bit: bit = 1 iff symbol > THRESHOLD (signed).
- Packs bits LSB-first into WORD_BITS-wide words and emits FRAME_WORDS words per frame downstream with backpressure.
- Frames are started by a start pulse and closed with a done pulse.

Parameters:
- DATA_WIDTH, 16, symbol width; two's complement.
- WORD_BITS, 8, bits per output word; must be ≥ 2.
- FRAME_WORDS, 4, words per frame; must be ≥ 1.
- THRESHOLD, 0, signed decision threshold; bit = 1 iff sym > THRESHOLD.
- MARGIN, 192, unsigned low-confidence bound; used only by the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- sym_in  in  DATA_WIDTH  signed input symbol
- sym_valid  in  1  symbol valid
- sym_ready  out  1  sequencer accepts a symbol
- bits_out  out  WORD_BITS  packed decision word; bit 0 is the first symbol
- bits_valid  out  1  word valid
- bits_ready  in  1  downstream accepts the word
- word_idx  out  clog2(FRAME_WORDS)+1  index of the word in bits_out within the frame
- erasure_cnt  out  clog2(WORD_BITS*FRAME_WORDS)+1  present only with SYM_ERASURE_COUNT_EN

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, sym_ready, bits_valid all 0. bits_out, word_idx, erasure_cnt, internal bit_cnt, word_cnt and shift register all 0.
- States: IDLE, COLLECT, OUTPUT, DONE.
- IDLE:
  - sym_ready=0, bits_valid=0.
  - start=1 → COLLECT; clear bit_cnt, word_cnt and shift register.
- COLLECT:
  - sym_ready=1.
  - On each handshake (sym_valid & sym_ready): write the decision bit at position bit_cnt, then bit_cnt++.
  - Handshake with bit_cnt==WORD_BITS-1 → latch the full word into bits_out and word_idx=word_cnt; go to OUTPUT; bit_cnt=0.
  - No handshake: hold state and all registers.
- OUTPUT:
  - bits_valid=1, sym_ready=0.
  - bits_out and word_idx stay stable while bits_valid=1 and bits_ready=0.
  - On bits_ready:
    - word_cnt==FRAME_WORDS-1 → DONE.
    - Otherwise word_cnt++ and go to COLLECT.
- DONE: done=1 for exactly one cycle, then IDLE. busy is 0 from IDLE onward.
- Latency:
  - bits_valid rises the cycle after the handshake of the last symbol of a word.
  - done rises the cycle after the final word handshake.
  - Peak throughput is WORD_BITS+1 cycles per word; collection does not overlap output.
- Decision: signed compare of the full DATA_WIDTH, sym > THRESHOLD. Examples with THRESHOLD=0: 0→0, -200→0, 200→1. Most negative value (-2^(DATA_WIDTH-1))→0.
- start while busy: ignored, no restart.
- sym_valid in IDLE, OUTPUT or DONE: not accepted (sym_ready=0).
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded and no done is issued.
- start asserted in the same cycle as the DONE→IDLE transition: ignored. It is sampled only while in IDLE.

Optional Feature:
- Macro: SYM_ERASURE_COUNT_EN.
- Defined:
  - erasure_cnt port exists.
  - Counts accepted symbols with |sym| < MARGIN in the current frame.
  - |x| is computed in DATA_WIDTH+1 bits so the most negative value counts as large.
  - Cleared on start; final value held from DONE until the next start.
- Not defined: the port and all counting logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-COLLECT after 3 symbols → all outputs 0 immediately and state IDLE; new start then yields a clean frame whose first word contains none of the old bits.
- WORD_BITS=8, FRAME_WORDS=1, start, symbols {200,-200,0,193,1,-1,32767,-32768} with sym_valid always high → bits_out=8'b0101_1001, word_idx=0, bits_valid 1 cycle after 8th handshake; done pulses 1 cycle after bits_ready.
- FRAME_WORDS=4, bits_ready held 0 for 5 cycles on word 2 → bits_out and word_idx=2 stable throughout, sym_ready=0; exactly 32 symbols are consumed, done pulses once.
- sym_valid toggling 1/0 each cycle → 8 decisions still packed in order; no bit is lost or duplicated.
- start re-pulsed during COLLECT → ignored; frame completes normally with word_idx sequence 0,1,2,3.
- SYM_ERASURE_COUNT_EN, MARGIN=192, symbols {0,191,192,-191,-192,-32768,100,300} → erasure_cnt=4 after done; reset to 0 on the next start.

Source files
------------

// File: rtl/symbol_frame_sequencer.sv
// symbol_frame_sequencer
//   Hard-decision slicer sequencer. Accepts signed symbols over a
//   valid/ready handshake. Each symbol is sliced to one bit
//   (bit = sym > THRESHOLD, signed). Bits are packed LSB-first into
//   WORD_BITS-wide words. FRAME_WORDS words are emitted per frame
//   with backpressure. A start pulse opens a frame and a done pulse
//   closes it.
//
//   Optional macro SYM_ERASURE_COUNT_EN adds erasure_cnt. It counts
//   the accepted symbols with |sym| < MARGIN in the current frame.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   start                  frame start pulse, sampled only in IDLE
//   busy                   high whenever the sequencer is not IDLE
//   done                   one-cycle pulse after the last word is accepted
//   sym_in/valid/ready     symbol input handshake
//   bits_out/valid/ready   packed word output handshake
//   word_idx               index of bits_out within the frame
//   erasure_cnt            low-confidence symbol count (macro only)
module symbol_frame_sequencer #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          WORD_BITS   = 8,
  parameter int          FRAME_WORDS = 4,
  parameter int          THRESHOLD   = 0,
  parameter int unsigned MARGIN      = 192
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic [DATA_WIDTH-1:0]            sym_in,
  input  logic                             sym_valid,
  output logic                             sym_ready,
  output logic [WORD_BITS-1:0]             bits_out,
  output logic                             bits_valid,
  input  logic                             bits_ready,
  output logic [$clog2(FRAME_WORDS):0]     word_idx
`ifdef SYM_ERASURE_COUNT_EN
  ,
  output logic [$clog2(WORD_BITS*FRAME_WORDS):0] erasure_cnt
`endif
);

  localparam int BC_W = $clog2(WORD_BITS);
  localparam int WI_W = $clog2(FRAME_WORDS) + 1;
  localparam logic signed [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              state;
  logic [BC_W-1:0]      bit_cnt;
  logic [WI_W-1:0]      word_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic [WORD_BITS-1:0] word_next;
  logic                 decision;
  logic                 handshake;

  // sym_ready is registered and only ever high in COLLECT.
  always_comb begin
    decision  = $signed(sym_in) > THR;
    handshake = sym_valid & sym_ready;
    word_next = shreg;
    word_next[bit_cnt] = decision;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sym_ready  <= 1'b0;
      bits_valid <= 1'b0;
      bits_out   <= '0;
      word_idx   <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_COLLECT;
            busy      <= 1'b1;
            sym_ready <= 1'b1;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
          end
        end
        S_COLLECT: begin
          if (handshake) begin
            shreg <= word_next;
            if (bit_cnt == BC_W'(WORD_BITS - 1)) begin
              // Word complete: present it directly from the merged value.
              bits_out   <= word_next;
              word_idx   <= word_cnt;
              bit_cnt    <= '0;
              sym_ready  <= 1'b0;
              bits_valid <= 1'b1;
              state      <= S_OUTPUT;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (bits_ready) begin
            bits_valid <= 1'b0;
            if (word_cnt == WI_W'(FRAME_WORDS - 1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              word_cnt  <= word_cnt + WI_W'(1);
              sym_ready <= 1'b1;
              state     <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SYM_ERASURE_COUNT_EN
  localparam int EC_W = $clog2(WORD_BITS*FRAME_WORDS) + 1;

  logic [DATA_WIDTH:0] sym_ext;
  logic [DATA_WIDTH:0] sym_mag;
  logic                low_conf;

  // One extra bit keeps the magnitude of the most negative value positive.
  always_comb begin
    sym_ext  = {sym_in[DATA_WIDTH-1], sym_in};
    sym_mag  = sym_in[DATA_WIDTH-1] ? -sym_ext : sym_ext;
    low_conf = sym_mag < (DATA_WIDTH+1)'(MARGIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erasure_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      erasure_cnt <= '0;
    end else if (handshake && low_conf) begin
      erasure_cnt <= erasure_cnt + EC_W'(1);
    end
  end
`endif

endmodule
